exe_mem_stage_reg_elastic: RTL
==============================

Name: exe_mem_stage_reg_elastic

Overview:
Parametrised EXE->MEM pipeline register for the ARM core, replacing the fixed 32-bit, always-advancing stage register. Carries the control bits WB_en, MEM_R_EN and MEM_W_EN, plus ALU result, store value and destination register. Adds a valid/ready handshake with a one-entry skid buffer, so a multi-cycle SRAM in MEM can back-pressure EXE without a combinational ready path. Adds a synchronous flush for branch/exception squash.

Parameters:
DATA_W, 32, width of alu_result and st_val.
REG_ADDR_W, 4, width of dest (register file index).
GATE_CTRL, 1, when 1, wb_en/mem_r_en/mem_w_en outputs are forced 0 whenever out_valid=0.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  reset; asynchronous, active-high.
flush  in  1  synchronous squash of all held entries.
in_valid  in  1  EXE presents an instruction.
in_ready  out  1  stage can accept; registered, equals !skid_full.
wb_en_in  in  1  writeback enable.
mem_r_en_in  in  1  memory read enable.
mem_w_en_in  in  1  memory write enable.
alu_result_in  in  DATA_W  ALU result / memory address.
st_val_in  in  DATA_W  store data.
dest_in  in  REG_ADDR_W  destination register.
out_valid  out  1  MEM-side entry valid.
out_ready  in  1  MEM stage consumes the entry this cycle.
wb_en, mem_r_en, mem_w_en  out  1 each  control bits of the head entry, gated per GATE_CTRL.
alu_result  out  DATA_W  head entry ALU result.
st_val  out  DATA_W  head entry store value.
dest  out  REG_ADDR_W  head entry destination.
occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main slot (drives outputs) and skid slot. Each slot holds payload plus a valid bit. Outputs come straight from main-slot flops; no comb path from inputs to outputs.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (main valid), TWO (main+skid valid).
- EMPTY: accept -> ONE, main <= input.
- ONE, consume & accept: stay ONE, main <= input.
- ONE, consume only: -> EMPTY.
- ONE, accept only: -> TWO, skid <= input.
- ONE, neither: hold.
- TWO (in_ready=0, no accept possible), consume: -> ONE, main <= skid.
- TWO, no consume: hold.
- Latency 1 cycle, input edge to out_valid. Sustained throughput is 1/cycle while out_ready=1.
- in_ready is a flop, set to !(next state == TWO). It must not depend combinationally on out_ready.
- Payload registers load only on the moves above. Non-moving slots retain their value; there is no clearing on consume.
- flush=1: next state EMPTY, both valids cleared, and any accept in that cycle is discarded. flush has priority over all handshakes. Payload contents are don't-care. in_ready is 1 the following cycle.
- GATE_CTRL=1 and out_valid=0: wb_en, mem_r_en and mem_w_en read 0 (bubble has no side effects). alu_result, st_val and dest show stale data.
- Reset (async assert, any time, including in TWO): state EMPTY, all payload flops 0, out_valid=0, in_ready=1 after deassert, occupancy=0, all control outputs 0.
- First accept is possible on the first rising edge after rst deasserts.
- Widths are exact; there is no truncation or extension. DATA_W and REG_ADDR_W must be >=1.

Decomposition:
- Shared package (pipe_pkg): state enum {EMPTY, ONE, TWO}; packed struct exe_mem_payload_t {wb_en, mem_r_en, mem_w_en, alu_result[DATA_W], st_val[DATA_W], dest[REG_ADDR_W]}, parametrised via localparams or typedef in the instantiating scope.
- One natural sub-module: pipe_slot_reg, a load-enabled payload register with async reset, instantiated twice (main, skid).

Test Plan:
1. Reset: hold rst=1 for 20 ns, then release -> out_valid=0, in_ready=1, occupancy=0, all outputs 0; with GATE_CTRL=1, wb_en=0 even though wb_en_in=1.
2. Streaming: out_ready=1; drive 4 back-to-back entries, alu_result_in=0x0002AABE, 0x1EAED5, ... -> each appears 1 cycle later in order, occupancy stays 1, in_ready stays 1.
3. Backpressure: out_ready=0; accept A (dest=7), then B (dest=3) -> occupancy=2, in_ready=0, outputs hold A. Raise out_ready -> A consumed, next cycle B shown, in_ready=1.
4. Simultaneous: in state ONE, consume and accept in the same cycle, st_val_in=0x0FFEBAA9 -> state stays ONE, new entry visible next cycle, no loss or duplication.
5. Flush: state TWO with in_valid=1, assert flush for 1 cycle -> occupancy=0, out_valid=0, mem_w_en=0, in_ready=1 next cycle, the flushed-cycle input is never output.
6. Mid-operation reset: in state TWO, pulse rst asynchronously off-edge -> outputs 0 immediately; after release, the next accepted entry is output normally.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and helpers for the elastic EXE->MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    // wb_en, mem_r_en, mem_w_en
    localparam int c_CTRL_W = 3;

    // Packed size of exe_mem_payload_t for a given DATA_W / REG_ADDR_W.
    function automatic int payload_width(input int data_w, input int reg_addr_w);
        return c_CTRL_W + 2 * data_w + reg_addr_w;
    endfunction

    function automatic logic [1:0] state_occupancy(input pipe_state_t state);
        logic [1:0] occ;
        case (state)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot_reg
// Description : Load-enabled payload register with asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================

module pipe_slot_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/exe_mem_stage_reg_elastic.sv
`default_nettype none
// ============================================================================
// Module      : exe_mem_stage_reg_elastic
// Description : EXE->MEM pipeline register with valid/ready handshake,
//               one-entry skid buffer and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================

module exe_mem_stage_reg_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int GATE_CTRL  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     st_val_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     st_val,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     st_val;
        logic [REG_ADDR_W-1:0] dest;
    } exe_mem_payload_t;

    localparam int c_PAYLOAD_W = payload_width(DATA_W, REG_ADDR_W);

    pipe_state_t      r_state;
    pipe_state_t      w_next_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_occupancy;

    logic             w_accept;
    logic             w_consume;
    logic             w_main_load;
    logic             w_main_from_skid;
    logic             w_skid_load;

    exe_mem_payload_t w_in_payload;
    exe_mem_payload_t w_main_d;
    exe_mem_payload_t w_main_q;
    exe_mem_payload_t w_skid_q;

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = r_out_valid & out_ready;

    assign w_in_payload.wb_en      = wb_en_in;
    assign w_in_payload.mem_r_en   = mem_r_en_in;
    assign w_in_payload.mem_w_en   = mem_w_en_in;
    assign w_in_payload.alu_result = alu_result_in;
    assign w_in_payload.st_val     = st_val_in;
    assign w_in_payload.dest       = dest_in;

    // Slot moves; flush suppresses every load so a squashed accept never lands.
    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ST_ONE;
                        w_main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_consume && w_accept) begin
                        w_main_load = 1'b1;
                    end else if (w_consume) begin
                        w_next_state = ST_EMPTY;
                    end else if (w_accept) begin
                        w_next_state = ST_TWO;
                        w_skid_load  = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_consume) begin
                        w_next_state     = ST_ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_payload;

    // in_ready is derived from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != ST_TWO);
            r_out_valid <= (w_next_state != ST_EMPTY);
            r_occupancy <= state_occupancy(w_next_state);
        end
    end

    pipe_slot_reg #(
        .WIDTH (c_PAYLOAD_W)
    ) u_main_slot (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    pipe_slot_reg #(
        .WIDTH (c_PAYLOAD_W)
    ) u_skid_slot (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_d    (w_in_payload),
        .o_q    (w_skid_q)
    );

    generate
        if (GATE_CTRL != 0) begin : g_gate_ctrl
            // A bubble must not trigger writeback or memory side effects.
            assign wb_en    = w_main_q.wb_en    & r_out_valid;
            assign mem_r_en = w_main_q.mem_r_en & r_out_valid;
            assign mem_w_en = w_main_q.mem_w_en & r_out_valid;
        end else begin : g_pass_ctrl
            assign wb_en    = w_main_q.wb_en;
            assign mem_r_en = w_main_q.mem_r_en;
            assign mem_w_en = w_main_q.mem_w_en;
        end
    endgenerate

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign occupancy  = r_occupancy;
    assign alu_result = w_main_q.alu_result;
    assign st_val     = w_main_q.st_val;
    assign dest       = w_main_q.dest;

endmodule

`default_nettype wire
